arb_mux_rr: RTL

Registered, parametrised N-way, W-bit multiplexer with built-in arbitration and valid/ready handshaking on every port. It generalises the fixed 2-way 8-bit select mux: the select comes from an internal round-robin or fixed-priority arbiter, not from an address input. It sits wherever several producers share one consumer, for example multiple requesters feeding a single memory or writeback port in the CPU datapath.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/arb_mux_rr.sv | 69 ++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated output mux: mode encodings and the
// index-width helper used to size channel indices.
package arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search starting at ptr (wrapping),
// or fixed priority (lowest index) when rr_en is low.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int IDX_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  input  logic                rr_en,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Walk candidates in priority order; the first requester wins.
    for (int j = 0; j < CHANNELS; j++) begin
      idx = (rr_en == MODE_RR) ? IDX_W'((int'(ptr) + j) % CHANNELS) : IDX_W'(j);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-way W-bit registered mux whose select comes from an internal arbiter,
// with valid/ready handshaking on every input channel and on the output.
module arb_mux_rr
  import arb_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int IDX_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rr_en,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]          out_chan
);

  logic                           r_valid;
  logic [WIDTH-1:0]               r_data;
  logic [IDX_W-1:0]               r_chan;
  logic [IDX_W-1:0]               r_ptr;

  logic                           w_load_en;
  logic                           w_xfer;
  logic [CHANNELS-1:0]            w_grant;
  logic [IDX_W-1:0]               w_grant_idx;
  logic [CHANNELS-1:0][WIDTH-1:0] w_chan_data;

  assign w_chan_data = in_data;
  assign w_load_en   = !r_valid || out_ready;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req      (in_valid),
    .ptr      (r_ptr),
    .rr_en    (rr_en),
    .grant    (w_grant),
    .grant_idx(w_grant_idx)
  );

  // Gated by reset so nothing looks accepted while the block is held.
  assign in_ready = reset ? '0 : (w_grant & {CHANNELS{w_load_en}});
  assign w_xfer   = |in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_chan_data[w_grant_idx];
      r_chan  <= w_grant_idx;
      if (rr_en == MODE_RR)
        r_ptr <= (w_grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule
